// File: rtl/core_pkg.sv
// Shared core definitions: default widths, instruction size and the fetch queue entry layout.
package core_pkg;

   localparam int unsigned XLEN_DEF    = 32;
   localparam int unsigned ILEN_DEF    = 32;
   localparam int unsigned INSTR_BYTES = 4;

   localparam logic [XLEN_DEF-1:0] RESET_PC_DEF = 32'h0000_0000;

   typedef struct packed {
      logic [XLEN_DEF-1:0] pc;
      logic [ILEN_DEF-1:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_pc_buffer_if.sv
// Fetch front-end bus: redirect input, IMEM port and decode-side dequeue port.
interface fetch_pc_buffer_if
   import core_pkg::*;
#(
   parameter int unsigned XLEN  = XLEN_DEF,
   parameter int unsigned ILEN  = ILEN_DEF,
   parameter int unsigned DEPTH = 4
);
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   logic             fetch_en;
   logic             redirect_valid;
   logic [XLEN-1:0]  redirect_pc;
   logic [XLEN-1:0]  imem_addr;
   logic [ILEN-1:0]  imem_rdata;
   logic             deq_ready;
   logic             deq_valid;
   logic [XLEN-1:0]  deq_pc;
   logic [XLEN-1:0]  deq_pc4;
   logic [ILEN-1:0]  deq_instr;
   logic [CNT_W-1:0] count;
   logic             full;
   logic             empty;

   // Environment side: control, IMEM data and decode acceptance.
   modport master (
      output fetch_en, redirect_valid, redirect_pc, imem_rdata, deq_ready,
      input  imem_addr, deq_valid, deq_pc, deq_pc4, deq_instr, count, full, empty
   );

   // Fetch buffer side.
   modport slave (
      input  fetch_en, redirect_valid, redirect_pc, imem_rdata, deq_ready,
      output imem_addr, deq_valid, deq_pc, deq_pc4, deq_instr, count, full, empty
   );

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush; enqueue into a full queue is legal when a dequeue happens in the same cycle.
module fetch_fifo #(
   parameter int unsigned WIDTH = 64,
   parameter int unsigned DEPTH = 4
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           enq,
   input  logic                           deq,
   input  logic                           flush,
   input  logic [WIDTH-1:0]               wdata,
   output logic [WIDTH-1:0]               rdata,
   output logic [$clog2(DEPTH+1)-1:0]     count,
   output logic                           full,
   output logic                           empty
);
   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             full_q, full_d;
   logic             empty_q, empty_d;
   logic             do_enq;
   logic             do_deq;

   // Flush overrides any transfer in the same cycle; pointers wrap since DEPTH is a power of 2.
   always_comb begin
      do_enq   = enq & ~flush;
      do_deq   = deq & ~flush;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_enq) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (do_deq) rd_ptr_d = rd_ptr_q + PTR_W'(1);
         case ({do_enq, do_deq})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
      full_d  = (count_d == CNT_W'(DEPTH));
      empty_d = (count_d == '0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         full_q   <= full_d;
         empty_q  <= empty_d;
      end
   end

   // Storage is not reset.
   always_ff @(posedge clk) begin
      if (do_enq) mem_q[wr_ptr_q] <= wdata;
   end

   assign rdata = mem_q[rd_ptr_q];
   assign count = count_q;
   assign full  = full_q;
   assign empty = empty_q;

endmodule

// File: rtl/fetch_pc_buffer.sv
// Fetch stage front end: PC generator feeding a prefetch queue of {pc, instr} pairs towards decode.
module fetch_pc_buffer
   import core_pkg::*;
#(
   parameter int unsigned     XLEN     = XLEN_DEF,
   parameter int unsigned     ILEN     = ILEN_DEF,
   parameter int unsigned     DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF)
) (
   input logic               clk,
   input logic               rst_n,
   fetch_pc_buffer_if.slave  bus
);
   localparam int unsigned ENTRY_W = XLEN + ILEN;
   localparam int unsigned CNT_W   = $clog2(DEPTH + 1);

   // Same layout as fetch_entry_t, sized by this instance's widths.
   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [ILEN-1:0] instr;
   } entry_t;

   logic [XLEN-1:0]  pc_q, pc_d;
   entry_t           wr_entry;
   entry_t           rd_entry;
   logic [ENTRY_W-1:0] rd_raw;
   logic [CNT_W-1:0] fifo_count;
   logic             fifo_full;
   logic             fifo_empty;
   logic             deq_valid;
   logic             enq;
   logic             deq;

   // Handshake: a redirect blocks both sides; a full queue may still enqueue on a same-cycle dequeue.
   always_comb begin
      deq_valid = ~fifo_empty & ~bus.redirect_valid;
      deq       = deq_valid & bus.deq_ready;
      enq       = bus.fetch_en & ~bus.redirect_valid & (~fifo_full | deq);
   end

   // Redirect target is word-aligned; otherwise the PC only advances on an enqueue.
   always_comb begin
      pc_d = pc_q;
      if (bus.redirect_valid) begin
         pc_d = {bus.redirect_pc[XLEN-1:2], 2'b00};
      end else if (enq) begin
         pc_d = pc_q + XLEN'(INSTR_BYTES);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) pc_q <= RESET_PC;
      else        pc_q <= pc_d;
   end

   always_comb begin
      wr_entry.pc    = pc_q;
      wr_entry.instr = bus.imem_rdata;
      rd_entry       = entry_t'(rd_raw);
   end

   fetch_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .enq   (enq),
      .deq   (deq),
      .flush (bus.redirect_valid),
      .wdata (wr_entry),
      .rdata (rd_raw),
      .count (fifo_count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign bus.imem_addr = pc_q;
   assign bus.deq_valid = deq_valid;
   assign bus.deq_pc    = rd_entry.pc;
   assign bus.deq_pc4   = rd_entry.pc + XLEN'(INSTR_BYTES);
   assign bus.deq_instr = rd_entry.instr;
   assign bus.count     = fifo_count;
   assign bus.full      = fifo_full;
   assign bus.empty     = fifo_empty;

endmodule
